// File: rtl/otter_timer_pkg.sv
// rtl/otter_timer_pkg.sv - register word indices and CTRL bit positions for the IOBUS timer
package otter_timer_pkg;

  localparam logic [2:0] TMR_CTRL     = 3'd0;
  localparam logic [2:0] TMR_PRESCALE = 3'd1;
  localparam logic [2:0] TMR_COMPARE  = 3'd2;
  localparam logic [2:0] TMR_COUNT    = 3'd3;
  localparam logic [2:0] TMR_STATUS   = 3'd4;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_RELOAD = 1;
  localparam int CTRL_INTEN  = 2;
  localparam int CTRL_W      = 3;

endpackage

// File: rtl/timer_prescaler.sv
// rtl/timer_prescaler.sv - free-running divider that emits one tick every limit+1 enabled cycles
module timer_prescaler #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clear,
  input  logic [W-1:0] limit,
  output logic         tick
);

  localparam logic [W-1:0] PC_ONE = W'(1);

  logic [W-1:0] pc;

  assign tick = en & (pc == limit);

  // A limit lowered below pc is not caught here: pc runs on and wraps before matching.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= '0;
    end else if (clear || !en || tick) begin
      pc <= '0;
    end else begin
      pc <= pc + PC_ONE;
    end
  end

endmodule

// File: rtl/otter_iobus_timer.sv
// rtl/otter_iobus_timer.sv - IOBUS responder: prescaled 32-bit compare timer with level interrupt
module otter_iobus_timer
  import otter_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h1100_0100,
  parameter int          PRESCALE_W = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] IOBUS_IN,
  output logic        INT
);

  logic                  sel;
  logic [2:0]            reg_idx;
  logic                  wr_en;
  logic                  count_wr;
  logic                  status_clr;
  logic                  tick;
  logic                  match;

  logic [CTRL_W-1:0]     ctrl;
  logic [PRESCALE_W-1:0] prescale;
  logic [31:0]           compare;
  logic [31:0]           count;
  logic                  pending;

  logic                  unused_addr_lsbs;

  assign sel        = (IOBUS_ADDR[31:5] == BASE_ADDR[31:5]);
  assign reg_idx    = IOBUS_ADDR[4:2];
  assign wr_en      = IOBUS_WR & sel;
  assign count_wr   = wr_en & (reg_idx == TMR_COUNT);
  assign status_clr = wr_en & (reg_idx == TMR_STATUS) & IOBUS_OUT[0];
  assign unused_addr_lsbs = ^IOBUS_ADDR[1:0];

  // A COUNT write pre-empts the tick, so no compare is evaluated on that edge.
  assign match = tick & ~count_wr & (count == compare);

  timer_prescaler #(
    .W(PRESCALE_W)
  ) u_prescaler (
    .clk  (CLK),
    .rst  (RST),
    .en   (ctrl[CTRL_EN]),
    .clear(count_wr),
    .limit(prescale),
    .tick (tick)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ctrl     <= '0;
      prescale <= '0;
      compare  <= 32'hFFFF_FFFF;
    end else if (wr_en) begin
      case (reg_idx)
        TMR_CTRL:     ctrl     <= IOBUS_OUT[CTRL_W-1:0];
        TMR_PRESCALE: prescale <= IOBUS_OUT[PRESCALE_W-1:0];
        TMR_COMPARE:  compare  <= IOBUS_OUT;
        default:      ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count <= '0;
    end else if (count_wr) begin
      count <= IOBUS_OUT;
    end else if (tick) begin
      if (match && ctrl[CTRL_RELOAD]) begin
        count <= '0;
      end else begin
        count <= count + 32'd1;
      end
    end
  end

  // Set beats a same-cycle write-1-to-clear so a match is never lost.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pending <= 1'b0;
    end else if (match) begin
      pending <= 1'b1;
    end else if (status_clr) begin
      pending <= 1'b0;
    end
  end

  always_comb begin
    IOBUS_IN = '0;
    if (sel) begin
      case (reg_idx)
        TMR_CTRL:     IOBUS_IN = 32'(ctrl);
        TMR_PRESCALE: IOBUS_IN = 32'(prescale);
        TMR_COMPARE:  IOBUS_IN = compare;
        TMR_COUNT:    IOBUS_IN = count;
        TMR_STATUS:   IOBUS_IN = {31'd0, pending};
        default:      IOBUS_IN = '0;
      endcase
    end
  end

  assign INT = pending & ctrl[CTRL_INTEN];

endmodule
